// File: rtl/arvi_bus_pkg.sv
// rtl/arvi_bus_pkg.sv - shared types, state encodings and round-robin helper for bus arbiters
//
// Purpose: common definitions imported by bus_arbiter and rr_picker.
//   ARVI_XLEN    : bus address/data width the request struct is built for.
//   RR_MAX_REQ   : widest request vector rr_next_idx can scan.
//   bus_req_t    : one master's latched transaction fields.
//   rr_next_idx  : first requester after 'last', scanning upward with wrap.
package arvi_bus_pkg;

  localparam int ARVI_XLEN  = 32;
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ARB_IDLE,
    S_BUSY = ARB_BUSY
  } arb_state_t;

  typedef struct packed {
    logic                 wr_en;
    logic [ARVI_XLEN-1:0] wr_data;
    logic [ARVI_XLEN-1:0] addr;
    logic [3:0]           byte_en;
  } bus_req_t;

  // Scans (last+1)..(last+n) mod n; the first set bit wins. Returns 0 when
  // nothing is requested, so callers qualify the result with |req.
  function automatic int rr_next_idx(input logic [RR_MAX_REQ-1:0] req,
                                     input int n, input int last);
    int   idx;
    int   cand;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= n) begin
        cand = (last + k) % n;
        if (!found && req[cand[RR_IDX_W-1:0]]) begin
          idx   = cand;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
//
// Purpose: picks the next requester after the last granted index.
// Ports:
//   i_req    : per-requester request bits.
//   i_last   : index granted most recently (lowest priority now).
//   o_valid  : at least one request present.
//   o_winner : selected requester index (meaningful when o_valid).
module rr_picker
  import arvi_bus_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_winner
);

  logic [RR_MAX_REQ-1:0] req_pad;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = i_req;
    o_valid        = |i_req;
    o_winner       = IW'(rr_next_idx(req_pad, N, int'(i_last)));
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one memory bus slave among masters
//
// Purpose: grants one master per transaction, holds the grant until the slave
// acks or the optional watchdog expires (error completion).
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset.
//   i_m_bus_en/wr_en      : per-master request and write flag.
//   i_m_wr_data/addr      : per-master data/address, master k at [k*XLEN +: XLEN].
//   i_m_byte_en           : per-master byte enables, master k at [k*4 +: 4].
//   o_m_ack/o_m_err       : one-hot completion (and error) to the granted master.
//   o_m_rd_data           : shared read data, zero unless an ack is issued.
//   o_s_*                 : registered slave request fields.
//   i_s_ack/i_s_rd_data   : slave completion and read data.
//   o_busy                : transaction in flight.
//   o_grant               : current or last granted master index.
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = ARVI_XLEN,
  parameter int TIMEOUT   = 0,
  localparam int IW = $clog2(N_MASTERS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_m_bus_en,
  input  logic [N_MASTERS-1:0]      i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*4-1:0]    i_m_byte_en,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [N_MASTERS-1:0]      o_m_err,
  output logic [XLEN-1:0]           o_m_rd_data,
  output logic                      o_s_bus_en,
  output logic                      o_s_wr_en,
  output logic [XLEN-1:0]           o_s_wr_data,
  output logic [XLEN-1:0]           o_s_addr,
  output logic [3:0]                o_s_byte_en,
  input  logic                      i_s_ack,
  input  logic [XLEN-1:0]           i_s_rd_data,
  output logic                      o_busy,
  output logic [IW-1:0]             o_grant
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  bus_req_t      req_q, req_d;
  logic          bus_en_q, bus_en_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  bus_req_t      pick_req;
  logic          timeout_hit;

  rr_picker #(.N(N_MASTERS)) u_picker (
    .i_req    (i_m_bus_en),
    .i_last   (last_q),
    .o_valid  (pick_valid),
    .o_winner (pick_idx)
  );

  assign timeout_hit = (TIMEOUT > 0) && (count_q == CW'(TIMEOUT - 1));

  // Mux the winning master's fields; constant slices keep the mux simple.
  always_comb begin
    pick_req = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (pick_idx == IW'(k)) begin
        pick_req.wr_en   = i_m_wr_en[k];
        pick_req.wr_data = i_m_wr_data[k*XLEN +: XLEN];
        pick_req.addr    = i_m_addr[k*XLEN +: XLEN];
        pick_req.byte_en = i_m_byte_en[k*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    count_d     = count_q;
    req_d       = req_q;
    bus_en_d    = bus_en_q;
    o_m_ack     = '0;
    o_m_err     = '0;
    o_m_rd_data = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d  = S_BUSY;
          grant_d  = pick_idx;
          req_d    = pick_req;
          bus_en_d = 1'b1;
          count_d  = '0;
        end
      end
      S_BUSY: begin
        // A reset cycle aborts silently, so completion is suppressed under i_rst.
        if (!i_rst && (i_s_ack || timeout_hit)) begin
          o_m_ack[grant_q] = 1'b1;
          if (i_s_ack) begin
            o_m_rd_data = i_s_rd_data;
          end else begin
            o_m_err[grant_q] = 1'b1;
          end
          state_d     = S_IDLE;
          bus_en_d    = 1'b0;
          req_d.wr_en = 1'b0;
          last_d      = grant_q;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= IW'(N_MASTERS - 1);
      count_q  <= '0;
      req_q    <= '0;
      bus_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      count_q  <= count_d;
      req_q    <= req_d;
      bus_en_q <= bus_en_d;
    end
  end

  assign o_s_bus_en  = bus_en_q;
  assign o_s_wr_en   = req_q.wr_en;
  assign o_s_wr_data = req_q.wr_data;
  assign o_s_addr    = req_q.addr;
  assign o_s_byte_en = req_q.byte_en;
  assign o_busy      = (state_q == S_BUSY);
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_bus_en;
  logic [1:0]  m_wr_en;
  logic [63:0] m_wr_data;
  logic [63:0] m_addr;
  logic [7:0]  m_byte_en;
  logic        s_ack;
  logic [31:0] s_rd_data;

  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rd_data;
  logic        s_bus_en, s_wr_en;
  logic [31:0] s_wr_data, s_addr;
  logic [3:0]  s_byte_en;
  logic        busy;
  logic        grant;

  logic [1:0]  t_m_ack, t_m_err;
  logic [31:0] t_m_rd_data;
  logic        t_s_bus_en, t_s_wr_en;
  logic [31:0] t_s_wr_data, t_s_addr;
  logic [3:0]  t_s_byte_en;
  logic        t_busy;
  logic        t_grant;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.N_MASTERS(2), .XLEN(32), .TIMEOUT(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_bus_en(m_bus_en), .i_m_wr_en(m_wr_en), .i_m_wr_data(m_wr_data),
    .i_m_addr(m_addr), .i_m_byte_en(m_byte_en),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rd_data(m_rd_data),
    .o_s_bus_en(s_bus_en), .o_s_wr_en(s_wr_en), .o_s_wr_data(s_wr_data),
    .o_s_addr(s_addr), .o_s_byte_en(s_byte_en),
    .i_s_ack(s_ack), .i_s_rd_data(s_rd_data),
    .o_busy(busy), .o_grant(grant)
  );

  bus_arbiter #(.N_MASTERS(2), .XLEN(32), .TIMEOUT(4)) dut_to (
    .i_clk(clk), .i_rst(rst),
    .i_m_bus_en(m_bus_en), .i_m_wr_en(m_wr_en), .i_m_wr_data(m_wr_data),
    .i_m_addr(m_addr), .i_m_byte_en(m_byte_en),
    .o_m_ack(t_m_ack), .o_m_err(t_m_err), .o_m_rd_data(t_m_rd_data),
    .o_s_bus_en(t_s_bus_en), .o_s_wr_en(t_s_wr_en), .o_s_wr_data(t_s_wr_data),
    .o_s_addr(t_s_addr), .o_s_byte_en(t_s_byte_en),
    .i_s_ack(s_ack), .i_s_rd_data(s_rd_data),
    .o_busy(t_busy), .o_grant(t_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_bus_en  = '0;
    m_wr_en   = '0;
    m_wr_data = '0;
    m_addr    = '0;
    m_byte_en = '0;
    s_ack     = 1'b0;
    s_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [1:0] exp_ack [4];
  logic       exp_gnt [4];

  initial begin
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset state
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_s_bus_en", s_bus_en, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_m_ack", m_ack, 2'b00);
    check("rst_s_fields", {s_wr_en, s_addr, s_wr_data, s_byte_en}, 69'h0);

    // Single read from m1, slave acks 3 cycles after o_s_bus_en
    m_bus_en = 2'b10;
    m_addr[32 +: 32] = 32'h100;
    step();
    check("rd_s_bus_en", s_bus_en, 1'b1);
    check("rd_s_addr", s_addr, 32'h100);
    check("rd_s_wr_en", s_wr_en, 1'b0);
    check("rd_grant", grant, 1'b1);
    step();
    step();
    check("rd_no_early_ack", m_ack, 2'b00);
    step();
    s_ack = 1'b1;
    s_rd_data = 32'hDEADBEEF;
    #1;
    check("rd_m_ack", m_ack, 2'b10);
    check("rd_m_err", m_err, 2'b00);
    check("rd_m_rd_data", m_rd_data, 32'hDEADBEEF);
    check("to_ack_wins", t_m_ack, 2'b10);
    check("to_ack_wins_err", t_m_err, 2'b00);
    m_bus_en = 2'b00;
    step();
    s_ack = 1'b0;
    #1;
    check("rd_busy_fall", busy, 1'b0);
    check("rd_s_bus_en_fall", s_bus_en, 1'b0);
    check("rd_idle_ack", m_ack, 2'b00);
    check("rd_idle_rd_data", m_rd_data, 32'h0);

    // Both masters held: grants alternate 0,1,0,1
    do_reset();
    m_bus_en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr_grant%0d", i), grant, exp_gnt[i]);
      s_ack = 1'b1;
      #1;
      check($sformatf("rr_ack%0d", i), m_ack, exp_ack[i]);
      step();
      s_ack = 1'b0;
      #1;
      check($sformatf("rr_idle%0d", i), busy, 1'b0);
    end
    m_bus_en = 2'b00;

    // m0 write; o_s_* must hold even when master inputs change
    m_bus_en = 2'b01;
    m_wr_en = 2'b01;
    m_wr_data[0 +: 32] = 32'h12345678;
    m_addr[0 +: 32] = 32'h200;
    m_byte_en[0 +: 4] = 4'b0011;
    m_wr_data[32 +: 32] = 32'hAAAA5555;
    m_addr[32 +: 32] = 32'h300;
    m_byte_en[4 +: 4] = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_hold%0d", i),
            {s_wr_en, s_bus_en, s_byte_en, s_addr, s_wr_data},
            {1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678});
      if (i == 0) begin
        m_addr[0 +: 32] = 32'hFFF0;
        m_wr_data[0 +: 32] = 32'h0;
        m_byte_en[0 +: 4] = 4'b1100;
      end
      step();
    end
    s_ack = 1'b1;
    m_bus_en = 2'b00;
    #1;
    check("wr_m_ack", m_ack, 2'b01);
    check("wr_m_err", m_err, 2'b00);
    step();
    s_ack = 1'b0;
    #1;
    check("wr_done_wr_en", {busy, s_bus_en, s_wr_en}, 3'b000);

    // Watchdog: TIMEOUT=4, slave never acks
    do_reset();
    m_bus_en = 2'b01;
    s_rd_data = 32'hCAFEF00D;
    step();
    step();
    step();
    check("to_no_early", t_m_ack, 2'b00);
    step();
    check("to_m_ack", t_m_ack, 2'b01);
    check("to_m_err", t_m_err, 2'b01);
    check("to_rd_zero", t_m_rd_data, 32'h0);
    m_bus_en = 2'b00;
    step();
    check("to_s_bus_en_fall", t_s_bus_en, 1'b0);
    check("to_busy_fall", t_busy, 1'b0);

    // Reset during BUSY aborts silently; next arbitration picks m0
    do_reset();
    m_bus_en = 2'b10;
    step();
    check("ab_grant", grant, 1'b1);
    check("ab_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("ab_no_ack_in_rst", m_ack, 2'b00);
    step();
    rst = 1'b0;
    #1;
    check("ab_after", {busy, s_bus_en, m_ack}, 4'b0000);
    m_bus_en = 2'b11;
    step();
    check("ab_rearb_grant", grant, 1'b0);
    s_ack = 1'b1;
    m_bus_en = 2'b00;
    #1;
    check("ab_rearb_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0;
    #1;

    // Spurious slave ack in IDLE with no requests
    s_ack = 1'b1;
    s_rd_data = 32'h1234;
    #1;
    check("sp_no_ack", m_ack, 2'b00);
    check("sp_rd_zero", m_rd_data, 32'h0);
    step();
    s_ack = 1'b0;
    #1;
    check("sp_idle", {busy, s_bus_en}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one simple-format memory bus slave among N_MASTERS bus masters.
- Typical masters are per-hart bus converters, or a debug/DMA port beside a core.
- Grants one master per transaction and holds the grant until the slave acks, or until a watchdog timeout ends the transaction with an error.
- Sits between the masters' bus ports and the single memory/interconnect slave.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- XLEN, 32, address/data width.
- TIMEOUT, 0, BUSY cycles without ack before an error completion; 0 disables the watchdog.

Ports:
- i_clk  in  1  single clock; all state updates on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_m_bus_en  in  N_MASTERS  per-master request; held until that master's ack.
- i_m_wr_en  in  N_MASTERS  per-master write (1) / read (0).
- i_m_wr_data  in  N_MASTERS*XLEN  per-master write data; master k occupies slice [k*XLEN +: XLEN].
- i_m_addr  in  N_MASTERS*XLEN  per-master address; same slicing.
- i_m_byte_en  in  N_MASTERS*4  per-master byte enables.
- o_m_ack  out  N_MASTERS  one-hot completion pulse to the granted master.
- o_m_err  out  N_MASTERS  error qualifier, valid with o_m_ack.
- o_m_rd_data  out  XLEN  read data, shared by all masters; qualified by o_m_ack.
- o_s_bus_en  out  1  slave request (registered).
- o_s_wr_en  out  1  slave write enable (registered).
- o_s_wr_data  out  XLEN  slave write data (registered).
- o_s_addr  out  XLEN  slave address (registered).
- o_s_byte_en  out  4  slave byte enables (registered).
- i_s_ack  in  1  slave completion.
- i_s_rd_data  in  XLEN  slave read data, valid with i_s_ack.
- o_busy  out  1  high in the BUSY state.
- o_grant  out  $clog2(N_MASTERS)  index of the current or last granted master.

Behaviour:
- Reset (i_rst=1 at a posedge): state=IDLE; all o_s_* = 0; o_grant=0; last-grant pointer = N_MASTERS-1, so master 0 has top priority after reset; watchdog count = 0. Reset mid-transaction aborts it silently; no ack is issued.
- States: IDLE and BUSY.
- IDLE:
  - If any i_m_bus_en is set, the winner is the first requester scanning from (last+1) mod N_MASTERS upward, with wrap-around.
  - At the next edge: state<=BUSY; o_grant<=winner; o_s_* <= winner's fields; o_s_bus_en<=1; count<=0.
  - o_m_ack=0 and o_m_err=0 throughout IDLE. i_s_ack arriving in IDLE is ignored.
- BUSY:
  - o_s_* hold their latched values; master inputs are not re-sampled.
  - i_s_ack=1: o_m_ack[o_grant]=1 combinationally in the same cycle; o_m_rd_data=i_s_rd_data. At the next edge: state<=IDLE, o_s_bus_en<=0, o_s_wr_en<=0, last<=o_grant.
  - TIMEOUT>0, i_s_ack=0 and count==TIMEOUT-1: o_m_ack[o_grant]=1, o_m_err[o_grant]=1, o_m_rd_data=0. Next-edge actions are identical to an ack.
  - Otherwise count increments, saturating.
  - Simultaneous ack and timeout: ack wins, err=0.
- Latency:
  - Request seen in IDLE → o_s_bus_en high on the next cycle.
  - Slave ack → master ack in the same cycle.
  - At least one IDLE cycle between transactions, so back-to-back transactions from one master occur every 2 + slave-latency cycles.
- Fairness: the granted master becomes lowest priority for the next arbitration. Under saturation, masters 0..N-1 are served in strict rotation.
- The granted master dropping i_m_bus_en during BUSY does not abort; its ack is still pulsed.
- Slaves must not ack after o_s_bus_en falls. A late ack after a timeout is a slave protocol violation and is ignored only if it arrives in IDLE.
- o_m_rd_data is XLEN'0 whenever no ack is issued.

Decomposition:
- Shared package arvi_bus_pkg holds:
  - typedef bus_req_t {wr_en, wr_data, addr, byte_en};
  - localparams ARB_IDLE/ARB_BUSY;
  - a function for the round-robin next-index computation.
- One sub-module is natural: rr_picker (combinational request vector + last pointer → valid + winner index), reusable by future arbiters.
- The FSM, output registers and watchdog stay in bus_arbiter.

Test Plan:
- Reset then single read from m1 (addr 0x100, slave acks 3 cycles after o_s_bus_en) → o_s_addr=0x100 and o_s_wr_en=0 one cycle after request; o_m_ack=2'b10 in the ack cycle; o_m_rd_data equals i_s_rd_data (0xDEADBEEF); o_busy falls the next cycle.
- Both masters request in the same cycle right after reset → m0 granted first, m1 second. Both held continuously → grants alternate 0,1,0,1 over 4 transactions.
- m0 write (addr 0x200, data 0x12345678, byte_en 4'b0011) → o_s_* carry exactly those values and hold stable across 5 wait cycles until ack.
- TIMEOUT=4, slave never acks → o_m_ack[0]=o_m_err[0]=1 on the 4th BUSY cycle; o_m_rd_data=0; o_s_bus_en low next cycle. Ack and timeout in the same cycle → err=0.
- i_rst asserted during BUSY → next cycle o_s_bus_en=0, o_busy=0, no ack pulsed. The next arbitration with both masters requesting picks m0.
- Spurious i_s_ack in IDLE with no requests → no o_m_ack, state stays IDLE.
